regfile_write_arbiter: RTL and testbench

Shares the single write port of the riscv32 register file among NREQ writeback requesters, such as the ALU writeback and the load unit. Each requester uses a valid/ready handshake. A round-robin pointer picks one requester per cycle, and a registered output stage drives the register file's write_enabled, write_location and write_data inputs. An optional post-reset sequencer zeroes every register before normal traffic is accepted.

---
 rtl/regfile_pkg.sv | 6 +
 rtl/regfile_write_arbiter_if.sv | 22 ++
 rtl/rr_picker.sv | 24 ++
 rtl/regfile_write_arbiter.sv | 63 ++++++
 tb/tb_regfile_write_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the register-file write path
package regfile_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  typedef logic [4:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester handshakes plus the register-file write port
interface regfile_write_arbiter_if import regfile_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int NREQ = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  reg_idx_t [NREQ-1:0] req_location;
  logic [NREQ-1:0][WIDTH-1:0] req_data;
  logic write_enabled;
  reg_idx_t write_location;
  logic [WIDTH-1:0] write_data;
  logic busy;
  modport master (
    output req_valid, req_location, req_data,
    input req_ready, write_enabled, write_location, write_data, busy
  );
  modport slave (
    input req_valid, req_location, req_data,
    output req_ready, write_enabled, write_location, write_data, busy
  );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: round-robin pick; search starts just above ptr and wraps
module rr_picker #(
  parameter int NREQ = 2,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);
  logic [PW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = PW'((int'(ptr) + k) % NREQ);
      idx = req[j] ? j : idx;
    end
    any = |req;
    grant = '0;
    grant[idx] = any;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register-file write port;
// define RF_CLEAR_EN to zero all registers after reset before accepting traffic
module regfile_write_arbiter import regfile_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SIZE = 32,
  parameter int NREQ = 2
) (
  input logic clk,
  input logic reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  if (SIZE < 1 || SIZE > 32 || NREQ < 2) begin : g_bad_cfg
    $error("regfile_write_arbiter: unsupported SIZE/NREQ");
  end
  logic [PW-1:0] ptr, gidx;
  logic [NREQ-1:0] grant;
  logic any, run, xfer;
  reg_idx_t clr_loc;
  rr_picker #(.NREQ(NREQ)) u_pick (
    .req(bus.req_valid), .ptr(ptr), .grant(grant), .idx(gidx), .any(any)
  );
`ifdef RF_CLEAR_EN
  state_t state, state_d;
  reg_idx_t cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CLEAR;
      cnt <= REG_ZERO;
    end else begin
      state <= state_d;
      cnt <= (state == CLEAR) ? cnt + 5'd1 : REG_ZERO;
    end
  always_comb state_d = (state == CLEAR && cnt == 5'(SIZE - 1)) ? RUN : state;
  assign run = state == RUN;
  assign clr_loc = cnt;
`else
  assign run = 1'b1;
  assign clr_loc = REG_ZERO;
`endif
  assign xfer = run & any;
  assign bus.req_ready = (run && !reset) ? grant : '0;
  assign bus.busy = ~run;
  // x0 transfers are accepted and registered but never enable the write
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.write_enabled <= 1'b0;
      bus.write_location <= REG_ZERO;
      bus.write_data <= '0;
      ptr <= PW'(NREQ - 1);
    end else if (!run) begin
      bus.write_enabled <= 1'b1;
      bus.write_location <= clr_loc;
      bus.write_data <= '0;
    end else begin
      bus.write_enabled <= xfer && bus.req_location[gidx] != REG_ZERO;
      if (xfer) begin
        bus.write_location <= bus.req_location[gidx];
        bus.write_data <= bus.req_data[gidx];
        ptr <= gidx;
      end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_regfile_write_arbiter;
  import regfile_pkg::*;
  localparam int WIDTH = 32, SIZE = 32, NREQ = 2;
`ifdef RF_CLEAR_EN
  localparam int CLR_CYC = SIZE;
`else
  localparam int CLR_CYC = 0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  int vectors = 0, miscompares = 0;
  regfile_write_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();
  regfile_write_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;

  int m_ptr, m_clr;
  logic m_we;
  logic [4:0] m_loc;
  logic [31:0] m_data;
  logic [NREQ-1:0] m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] v, input int p);
    logic [NREQ-1:0] r = '0;
    for (int o = 1; o <= NREQ; o++)
      if (v[(p + o) % NREQ]) begin
        r[(p + o) % NREQ] = 1'b1;
        return r;
      end
    return r;
  endfunction

  always @(negedge clk) begin : cmp
    logic [NREQ-1:0] er;
    if (reset) begin
      m_ptr = NREQ - 1; m_clr = CLR_CYC; m_we = 1'b0; m_loc = '0; m_data = '0;
    end
    er = (!reset && m_clr == 0) ? pick(bus.req_valid, m_ptr) : '0;
    chk("m_ready", 32'(bus.req_ready), 32'(er));
    chk("m_we", 32'(bus.write_enabled), 32'(m_we));
    chk("m_loc", 32'(bus.write_location), 32'(m_loc));
    chk("m_data", bus.write_data, m_data);
    chk("m_busy", 32'(bus.busy), 32'(m_clr > 0));
    m_acc = er;
    if (!reset) begin
      if (m_clr > 0) begin
        m_we = 1'b1; m_loc = 5'(CLR_CYC - m_clr); m_data = '0; m_clr--;
      end else if (er != '0) begin
        for (int i = 0; i < NREQ; i++)
          if (er[i]) begin
            m_ptr = i; m_loc = bus.req_location[i]; m_data = bus.req_data[i];
            m_we = bus.req_location[i] != 5'd0;
          end
      end else m_we = 1'b0;
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic at_neg(); @(negedge clk); #1; endtask

  task automatic do_reset(input bit probe);
    reset = 1'b1;
    bus.req_valid = probe ? '1 : '0;
    bus.req_location[0] = 5'd1; bus.req_location[1] = 5'd2;
    step(); step(); at_neg();
    chk("rst_we", 32'(bus.write_enabled), 0);
    chk("rst_loc", 32'(bus.write_location), 0);
    chk("rst_data", bus.write_data, 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_busy", 32'(bus.busy), 32'(CLR_CYC > 0));
    step();
    reset = 1'b0;
`ifdef RF_CLEAR_EN
    for (int k = 0; k < SIZE; k++) begin
      at_neg();
      chk("clr_busy", 32'(bus.busy), 1);
      chk("clr_ready", 32'(bus.req_ready), 0);
      if (k > 0) begin
        chk("clr_we", 32'(bus.write_enabled), 1);
        chk("clr_loc", 32'(bus.write_location), 32'(k - 1));
        chk("clr_data", bus.write_data, 0);
      end
      step();
    end
    at_neg();
    chk("clr_last_loc", 32'(bus.write_location), 32'(SIZE - 1));
`else
    at_neg();
`endif
    chk("run_busy", 32'(bus.busy), 0);
    chk("first_grant", 32'(bus.req_ready), probe ? 1 : 0);
    step();
    bus.req_valid = '0;
  endtask

  initial begin
    logic [31:0] sd [3];
    logic [4:0] pl;
    int rcnt;
    sd = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    bus.req_valid = '0; bus.req_location = '0; bus.req_data = '0;
    do_reset(1'b1);
    // single requester, back-to-back
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = 2'b01; bus.req_location[0] = 5'(5 + k); bus.req_data[0] = sd[k];
      at_neg();
      chk("single_ready", 32'(bus.req_ready), 1);
      if (k > 0) begin
        chk("single_we", 32'(bus.write_enabled), 1);
        chk("single_loc", 32'(bus.write_location), 32'(4 + k));
        chk("single_data", bus.write_data, sd[k - 1]);
      end
      step();
    end
    bus.req_valid = '0;
    at_neg();
    chk("single_last_loc", 32'(bus.write_location), 7);
    chk("single_last_data", bus.write_data, sd[2]);
    step(); at_neg();
    chk("idle_we", 32'(bus.write_enabled), 0);
    chk("idle_loc_hold", 32'(bus.write_location), 7);
    step();
    // contention from reset priority
    do_reset(1'b0);
    bus.req_valid = 2'b11;
    bus.req_location[0] = 5'd10; bus.req_data[0] = 32'h1000;
    bus.req_location[1] = 5'd20; bus.req_data[1] = 32'h2000;
    pl = '0;
    for (int t = 0; t < 6; t++) begin
      at_neg();
      chk("cont_ready", 32'(bus.req_ready), (t % 2) ? 2 : 1);
      if (t > 0) begin
        chk("cont_we", 32'(bus.write_enabled), 1);
        chk("cont_loc", 32'(bus.write_location), 32'(pl));
      end
      pl = bus.req_location[t % 2];
      step();
      bus.req_location[t % 2] = pl + 5'd1;
      bus.req_data[t % 2] = bus.req_data[t % 2] + 32'd1;
    end
    bus.req_valid = '0;
    at_neg();
    chk("cont_last_loc", 32'(bus.write_location), 32'(pl));
    step();
    // x0 filter
    do_reset(1'b0);
    bus.req_valid = 2'b10; bus.req_location[1] = 5'd0; bus.req_data[1] = 32'hFFFF_FFFF;
    at_neg();
    chk("x0_ready", 32'(bus.req_ready), 2);
    step();
    bus.req_valid = 2'b11;
    bus.req_location[0] = 5'd3; bus.req_data[0] = 32'h33;
    bus.req_location[1] = 5'd4; bus.req_data[1] = 32'h44;
    at_neg();
    chk("x0_we", 32'(bus.write_enabled), 0);
    chk("x0_data", bus.write_data, 32'hFFFF_FFFF);
    chk("x0_next_ready", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = '0;
    at_neg();
    chk("x0_after_loc", 32'(bus.write_location), 3);
    step();
    // idle cycles keep priority
    do_reset(1'b0);
    bus.req_valid = 2'b10; bus.req_location[1] = 5'd12; bus.req_data[1] = 32'h12;
    at_neg();
    chk("hold_ready", 32'(bus.req_ready), 2);
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("hold_we", 32'(bus.write_enabled), (i == 0) ? 1 : 0);
      step();
    end
    bus.req_valid = 2'b11; bus.req_location[0] = 5'd13; bus.req_location[1] = 5'd14;
    at_neg();
    chk("hold_idle_we", 32'(bus.write_enabled), 0);
    chk("hold_grant", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = '0;
    // reset right after an acceptance drops the pending write
    bus.req_valid = 2'b01; bus.req_location[0] = 5'd9; bus.req_data[0] = 32'h99;
    at_neg();
    chk("mr_ready", 32'(bus.req_ready), 1);
    step();
    chk("mr_we_before", 32'(bus.write_enabled), 1);
    reset = 1'b1;
    #1;
    chk("mr_we_async", 32'(bus.write_enabled), 0);
    chk("mr_loc_async", 32'(bus.write_location), 0);
    bus.req_valid = '0;
    do_reset(1'b0);
    // randomized traffic obeying the hold-until-accepted rule
    rcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) reset = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1; rcnt = 2;
      end
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i] || m_acc[i]) begin
          bus.req_valid[i] = $urandom_range(0, 3) != 0;
          bus.req_location[i] = 5'($urandom_range(0, 7));
          bus.req_data[i] = $urandom;
        end
      step();
    end
    reset = 1'b0;
    bus.req_valid = '0;
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
